modmul_barret_2017: RTL

- Pipelined modular multiplier: computes (a*b) mod Q for Q = 2017 and returns an 11-bit residue.
- Drives Barrett reduction from the producer side. It forms the full product, reduces it sequentially, and wraps the datapath in valid/ready handshakes.
- Sits between NTT/butterfly control and residue storage; replaces the purely combinational reduce path in timing-critical loops.

---
 rtl/barret_pkg.sv | 14 +
 rtl/barret_reduce_stage.sv | 25 ++
 rtl/modmul_barret_2017.sv | 49 ++++
 3 files changed

// File: rtl/barret_pkg.sv
// barret_pkg: Barrett constants for Q = 2017 and the shared residue type
package barret_pkg;
  localparam int Q = 2017;
  localparam int W = 11;
  localparam int K = 22;
  localparam int MU = 2079;
  localparam int PW = 2 * W;
  localparam int BW = 33;
  localparam int RW = 13;
  typedef logic [W-1:0] residue_t;
  typedef logic [RW-1:0] r0_t;
  localparam r0_t Q_R = r0_t'(Q);
  localparam residue_t Q_W = residue_t'(Q);
endpackage

// File: rtl/barret_reduce_stage.sv
// barret_reduce_stage: S2 Barrett estimate and S3 double conditional subtract, both registered
module barret_reduce_stage import barret_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [PW-1:0] p,
  output logic [W-1:0]  r
);
  logic [BW-1:0] bp;
  logic [W-1:0]  t;
  logic [RW-1:0] r0_d, r0, r1, r2;
  assign bp = BW'(p) * BW'(MU);
  assign t = bp[K+W-1:K];
  assign r0_d = r0_t'(p) - r0_t'(t) * Q_R;
  assign r1 = r0 >= Q_R ? r0 - Q_R : r0;
  assign r2 = r1 >= Q_R ? r1 - Q_R : r1;
  // S2: coarse remainder, at most 2Q too large
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r0 <= '0;
    else if (en) r0 <= r0_d;
  // S3: fully reduced residue, held while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (en) r <= r2[W-1:0];
endmodule

// File: rtl/modmul_barret_2017.sv
// modmul_barret_2017: 3-stage (a*b) mod 2017 with valid/ready; MODMUL_RANGE_CHK_EN adds out_err
module modmul_barret_2017 import barret_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef MODMUL_RANGE_CHK_EN
  output logic         out_err,
`endif
  output logic [W-1:0] out_r
);
  logic          v1, v2, v3, en;
  logic [PW-1:0] prod, p_d, p;
  assign in_ready = !v3 | out_ready;
  assign en = in_ready;
  assign out_valid = v3;
  assign prod = PW'(in_a) * PW'(in_b);
`ifdef MODMUL_RANGE_CHK_EN
  logic bad, e1, e2, e3;
  assign bad = in_a >= Q_W || in_b >= Q_W;
  assign p_d = bad ? '0 : prod;
  assign out_err = e3;
  // error flag travels with its transaction so it stays aligned with out_r
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {e1, e2, e3} <= '0;
    else if (en) {e1, e2, e3} <= {bad, e1, e2};
`else
  assign p_d = prod;
`endif
  // global stall: every stage valid bit advances together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v1, v2, v3} <= '0;
    else if (en) {v1, v2, v3} <= {in_valid, v1, v2};
  // S1: full 22-bit product
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else if (en) p <= p_d;
  barret_reduce_stage u_red (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .p     (p),
    .r     (out_r)
  );
endmodule
